// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide sequencer.
//   DATA_W  - operand / HI / LO width, also the number of iterations per op
//   CNT_W   - iteration counter width (must hold DATA_W-1)
//   state_t - sequencer states
//   magnitude() - low DATA_W bits of |v| for a 33-bit extended operand
package muldiv_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // The extended operand carries its own sign in bit DATA_W, so the
  // magnitude of the most negative value still fits in DATA_W bits.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W:0] v);
    logic [DATA_W:0] m;
    m = v[DATA_W] ? -v : v;
    return m[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: shared shift datapath for unsigned shift-add multiply and
// restoring divide, one iteration per 'step'.
//   clk, reset - clock and asynchronous active-high reset
//   load       - capture op_a into the low half, op_b as multiplicand/divisor
//   step       - perform one iteration
//   is_div     - selects restoring divide (1) or shift-add multiply (0)
//   op_a, op_b - unsigned operands (multiplier/dividend, multiplicand/divisor)
//   acc        - multiply: product; divide: {remainder, quotient}
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic                  is_div,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  output logic [2*DATA_W-1:0]   acc
);

  logic [2*DATA_W-1:0] acc_q;
  logic [DATA_W-1:0]   op_b_q;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     rem_shift;
  logic                rem_ge;
  logic [DATA_W-1:0]   rem_diff;
  logic [2*DATA_W-1:0] acc_next;

  // Multiply adds into the upper half and shifts right, keeping the carry.
  // Divide shifts left and subtracts the divisor when the partial remainder
  // (one bit wider after the shift) is large enough.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, op_b_q};
    rem_shift = acc_q[2*DATA_W-1:DATA_W-1];
    rem_ge    = rem_shift >= {1'b0, op_b_q};
    rem_diff  = DATA_W'(rem_shift - {1'b0, op_b_q});
    acc_next  = acc_q;
    if (is_div) begin
      if (rem_ge)
        acc_next = {rem_diff, acc_q[DATA_W-2:0], 1'b1};
      else
        acc_next = {acc_q[2*DATA_W-2:0], 1'b0};
    end else begin
      if (acc_q[0])
        acc_next = {mul_sum, acc_q[DATA_W-1:1]};
      else
        acc_next = {1'b0, acc_q[2*DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      op_b_q <= '0;
    end else if (load) begin
      acc_q  <= {{DATA_W{1'b0}}, op_a};
      op_b_q <= op_b;
    end else if (step) begin
      acc_q  <= acc_next;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: MULT/MULTU/DIV/DIVU sequencer and HI/LO register owner.
//   clk, reset       - clock and asynchronous active-high reset
//   de_valid         - instruction valid in execute
//   de_mul, de_div   - multiply / divide request
//   de_extend_rs/rt  - 33-bit sign- or zero-extended operands
//   de_mthi, de_mtlo - move-to-HI/LO request, data on de_mt_wdata
//   de_cancel        - flush; aborts any operation in flight
//   exe_stall        - hold decode/execute (combinational)
//   busy             - iterating a multiply or divide
//   hi_rdata, lo_rdata - HI and LO registers
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              de_valid,
  input  logic              de_mul,
  input  logic              de_div,
  input  logic [DATA_W:0]   de_extend_rs,
  input  logic [DATA_W:0]   de_extend_rt,
  input  logic              de_mthi,
  input  logic              de_mtlo,
  input  logic [DATA_W-1:0] de_mt_wdata,
  input  logic              de_cancel,
  output logic              exe_stall,
  output logic              busy,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                op_div_q, sign_q, rs_sign_q, dz_q;
  logic [DATA_W-1:0]   dz_hi_q;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] prod_neg;
  logic [DATA_W-1:0]   res_hi, res_lo;
  logic                idle_valid, accept_mul, accept_div, accept_dz, mt_wr;
  logic                iterating, last_iter;

  // Multiply wins over divide, and either wins over a move-to.
  assign idle_valid = (state_q == ST_IDLE) && de_valid && !de_cancel;
  assign accept_mul = idle_valid && de_mul;
  assign accept_div = idle_valid && !de_mul && de_div && (de_extend_rt != '0);
  assign accept_dz  = idle_valid && !de_mul && de_div && (de_extend_rt == '0);
  assign mt_wr      = idle_valid && !de_mul && !de_div && (de_mthi || de_mtlo);
  assign iterating  = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign last_iter  = cnt_q == CNT_W'(DATA_W - 1);

  muldiv_iter u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (accept_mul || accept_div),
    .step   (iterating),
    .is_div (op_div_q),
    .op_a   (magnitude(de_extend_rs)),
    .op_b   (magnitude(de_extend_rt)),
    .acc    (acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_mul)      state_d = ST_MUL;
        else if (accept_div) state_d = ST_DIV;
        else if (accept_dz)  state_d = ST_DONE;
      end
      ST_MUL, ST_DIV: begin
        if (de_cancel)      state_d = ST_IDLE;
        else if (last_iter) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    exe_stall = (accept_mul || accept_div || accept_dz) || iterating;
    busy      = iterating;
  end

  // Operation context captured on accept; the counter only restarts there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      op_div_q  <= 1'b0;
      sign_q    <= 1'b0;
      rs_sign_q <= 1'b0;
      dz_q      <= 1'b0;
      dz_hi_q   <= '0;
    end else if (accept_mul || accept_div) begin
      cnt_q     <= '0;
      op_div_q  <= accept_div;
      sign_q    <= de_extend_rs[DATA_W] ^ de_extend_rt[DATA_W];
      rs_sign_q <= de_extend_rs[DATA_W];
      dz_q      <= 1'b0;
    end else if (accept_dz) begin
      op_div_q  <= 1'b1;
      dz_q      <= 1'b1;
      dz_hi_q   <= de_extend_rs[DATA_W-1:0];
    end else if (iterating) begin
      cnt_q     <= cnt_q + CNT_W'(1);
    end
  end

  // Sign fix-up: the datapath works on magnitudes only.
  always_comb begin
    prod_neg = -acc;
    if (dz_q) begin
      res_hi = dz_hi_q;
      res_lo = '1;
    end else if (op_div_q) begin
      res_hi = rs_sign_q ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
      res_lo = sign_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    end else begin
      res_hi = sign_q ? prod_neg[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
      res_lo = sign_q ? prod_neg[DATA_W-1:0] : acc[DATA_W-1:0];
    end
  end

  // HI/LO change only when a result retires or on a move-to; no bypass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if ((state_q == ST_DONE) && !de_cancel) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (mt_wr) begin
      if (de_mthi) hi_q <= de_mt_wdata;
      if (de_mtlo) lo_q <= de_mt_wdata;
    end
  end

  assign hi_rdata = hi_q;
  assign lo_rdata = lo_q;

endmodule
